// File: rtl/trig_out_router.sv
// trig_out_router: routes N level trigger sources to the CW trigger output.
// The sources are masked and combined in one of four ways: OR, AND, a two-step
// sequence (src0 then src1), or a live passthrough of a single source. An armed
// match starts a one-shot trigger with a programmable delay and pulse width.
// An idle heartbeat counter drives the capture status LED.
// Optional feature: define TRIG_EVENT_COUNT_EN to build the saturating
// O_event_count counter. Without it, O_event_count is tied to zero.
// O_dbg_state exposes the FSM state for checkers.
module trig_out_router #(
  parameter int pNUM_SRC     = 4,
  parameter int pDELAY_WIDTH = 16,
  parameter int pWIDTH_WIDTH = 16,
  parameter int pLED_WIDTH   = 23
) (
  input  logic                        ext_clock,
  input  logic                        resetn,
  input  logic [pNUM_SRC-1:0]         I_src,
  input  logic [pNUM_SRC-1:0]         I_mask,
  input  logic [1:0]                  I_mode,
  input  logic [$clog2(pNUM_SRC)-1:0] I_pass_idx,
  input  logic                        I_arm,
  input  logic [pDELAY_WIDTH-1:0]     I_delay,
  input  logic [pWIDTH_WIDTH-1:0]     I_width,
  output logic                        O_trig,
  output logic                        O_armed,
  output logic                        O_busy,
  output logic                        O_led_heartbeat,
  output logic [15:0]                 O_event_count,
  output logic [1:0]                  O_dbg_state
);

  localparam int CNT_W = (pDELAY_WIDTH > pWIDTH_WIDTH) ? pDELAY_WIDTH : pWIDTH_WIDTH;

  localparam logic [1:0] MODE_OR   = 2'd0;
  localparam logic [1:0] MODE_AND  = 2'd1;
  localparam logic [1:0] MODE_SEQ  = 2'd2;
  localparam logic [1:0] MODE_PASS = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_DELAY, S_PULSE} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [pNUM_SRC-1:0]     mask_q, mask_d;
  logic [1:0]              mode_q, mode_d;
  logic [pDELAY_WIDTH-1:0] delay_q, delay_d;
  logic [pWIDTH_WIDTH-1:0] width_q, width_d;
  logic [pNUM_SRC-1:0]     src_q, src_d;
  logic                    seq_q, seq_d;
  logic                    match_q, match_d;
  logic                    fire_q, fire_d;
  logic                    trig_q, trig_d;
  logic [pLED_WIDTH-1:0]   led_q, led_d;
  logic                    match;
  logic                    routed;
  logic                    pass;
  logic [CNT_W-1:0]        width_len;

  // Combined match for a given config; SEQ sees only the src1 rise once src0 has risen.
  function automatic logic match_of(input logic [pNUM_SRC-1:0] src,
                                    input logic [pNUM_SRC-1:0] src_prev,
                                    input logic [pNUM_SRC-1:0] mask,
                                    input logic [1:0]          mode,
                                    input logic                seq);
    logic m;
    m = 1'b0;
    case (mode)
      MODE_OR:  m = |(src & mask);
      MODE_AND: m = (&(src | ~mask)) && (mask != '0);
      MODE_SEQ: m = mask[0] && mask[1] && seq && src[1] && !src_prev[1];
      default:  m = 1'b0;
    endcase
    return m;
  endfunction

  // Passthrough source select; an index past the last source reads 0.
  always_comb begin
    routed = 1'b0;
    for (int i = 0; i < pNUM_SRC; i++) begin
      if (int'(I_pass_idx) == i) routed = I_src[i];
    end
  end

  // Next-state logic: PASS overrides everything, otherwise the one-shot FSM.
  always_comb begin
    pass      = (I_mode == MODE_PASS);
    match     = match_of(I_src, src_q, mask_q, mode_q, seq_q);
    width_len = (width_q == '0) ? CNT_W'(1) : CNT_W'(width_q);
    state_d   = state_q;
    cnt_d     = cnt_q;
    mask_d    = mask_q;
    mode_d    = mode_q;
    delay_d   = delay_q;
    width_d   = width_q;
    src_d     = I_src;
    seq_d     = seq_q;
    match_d   = match;
    fire_d    = 1'b0;
    trig_d    = 1'b0;
    if (pass) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      trig_d  = routed;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (I_arm) begin
            state_d = S_ARMED;
            mask_d  = I_mask;
            mode_d  = I_mode;
            delay_d = I_delay;
            width_d = I_width;
            seq_d   = 1'b0;
            // Prime the edge detector with the new config so a level already high never fires.
            match_d = match_of(I_src, src_q, I_mask, I_mode, 1'b0);
          end
        end
        S_ARMED: begin
          if (fire_q) begin
            if (delay_q == '0) begin
              state_d = S_PULSE;
              cnt_d   = width_len;
              trig_d  = 1'b1;
            end else begin
              state_d = S_DELAY;
              cnt_d   = CNT_W'(delay_q);
            end
          end else begin
            fire_d = match && !match_q;
          end
          if (I_src[0] && !src_q[0]) seq_d = 1'b1;
        end
        S_DELAY: begin
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_PULSE;
            cnt_d   = width_len;
            trig_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        S_PULSE: begin
          if (cnt_q == CNT_W'(1)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d  = cnt_q - CNT_W'(1);
            trig_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Heartbeat only advances while quiet so LED switching stays out of captures.
  always_comb begin
    led_d = led_q;
    if ((state_q == S_IDLE) && !trig_q) led_d = led_q + pLED_WIDTH'(1);
  end

  // State and configuration registers.
  always_ff @(posedge ext_clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
      mode_q  <= '0;
      delay_q <= '0;
      width_q <= '0;
      src_q   <= '0;
      seq_q   <= 1'b0;
      match_q <= 1'b0;
      fire_q  <= 1'b0;
      trig_q  <= 1'b0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
      delay_q <= delay_d;
      width_q <= width_d;
      src_q   <= src_d;
      seq_q   <= seq_d;
      match_q <= match_d;
      fire_q  <= fire_d;
      trig_q  <= trig_d;
      led_q   <= led_d;
    end
  end

  assign O_trig          = trig_q;
  assign O_armed         = (state_q == S_ARMED);
  assign O_busy          = (state_q != S_IDLE);
  assign O_led_heartbeat = led_q[pLED_WIDTH-1];
  assign O_dbg_state     = state_q;

`ifdef TRIG_EVENT_COUNT_EN
  logic [15:0] evt_q, evt_d;
  logic        evt_inc;

  // Count pulse entries and passthrough rising edges, saturating at all-ones.
  always_comb begin
    evt_inc = ((state_d == S_PULSE) && (state_q != S_PULSE)) ||
              (pass && trig_d && !trig_q);
    evt_d   = evt_q;
    if (evt_inc && (evt_q != 16'hFFFF)) evt_d = evt_q + 16'd1;
  end

  // Event counter register, cleared only by reset.
  always_ff @(posedge ext_clock or negedge resetn) begin
    if (!resetn) evt_q <= '0;
    else         evt_q <= evt_d;
  end

  assign O_event_count = evt_q;
`else
  assign O_event_count = 16'h0000;
`endif

endmodule

// File: tb/tb_trig_out_router.sv
// tb_trig_out_router: randomized and directed stimulus for trig_out_router,
// with a cycle-level reference model built from trigger timing rules
// (fire edge, delay window, pulse window) and a queue-based scoreboard.
module tb_trig_out_router;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int WW = 16;
  localparam int LW = 4;
  localparam int EW = 20;

  logic          ext_clock = 1'b0;
  logic          resetn = 1'b0;
  logic [N-1:0]  I_src = '0;
  logic [N-1:0]  I_mask = '0;
  logic [1:0]    I_mode = 2'd0;
  logic [1:0]    I_pass_idx = 2'd0;
  logic          I_arm = 1'b0;
  logic [DW-1:0] I_delay = '0;
  logic [WW-1:0] I_width = '0;
  logic          O_trig, O_armed, O_busy, O_led_heartbeat;
  logic [15:0]   O_event_count;
  logic [1:0]    O_dbg_state;

  trig_out_router #(.pNUM_SRC(N), .pDELAY_WIDTH(DW), .pWIDTH_WIDTH(WW), .pLED_WIDTH(LW)) dut (
    .ext_clock(ext_clock), .resetn(resetn), .I_src(I_src), .I_mask(I_mask), .I_mode(I_mode),
    .I_pass_idx(I_pass_idx), .I_arm(I_arm), .I_delay(I_delay), .I_width(I_width),
    .O_trig(O_trig), .O_armed(O_armed), .O_busy(O_busy), .O_led_heartbeat(O_led_heartbeat),
    .O_event_count(O_event_count), .O_dbg_state(O_dbg_state)
  );

  // Clock and reset
  always #5 ext_clock = ~ext_clock;

  int checks = 0;
  int passes = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s @%0t: actual trig/busy/armed/hb=%b evt=%0d, required trig/busy/armed/hb=%b evt=%0d",
                  name, $time, act[EW-1:16], act[15:0], req[EW-1:16], req[15:0]);
  endtask

  // Reference model: one step per rising edge, outputs as seen after that edge
  typedef enum int {M_IDLE, M_ARMED, M_RUN} mphase_e;
  mphase_e      m_phase;
  int           t, m_fire_t, m_start, m_end, m_delay, m_wlen, m_ev;
  logic [N-1:0] m_mask, m_prev_src;
  logic [1:0]   m_mode;
  logic         m_seq, m_prev_match, m_trig, m_busy, m_armed;
  logic [LW-1:0] m_hb;

  function automatic logic match_of(input logic [N-1:0] src, input logic [N-1:0] prev,
                                    input logic [N-1:0] mask, input logic [1:0] mode, input logic seq);
    if (mode == 2'd0) return |(src & mask);
    if (mode == 2'd1) return (mask != 0) && ((src & mask) == mask);
    if (mode == 2'd2) return mask[0] && mask[1] && seq && src[1] && !prev[1];
    return 1'b0;
  endfunction

  task automatic model_reset();
    m_phase = M_IDLE; m_fire_t = -1; m_start = 0; m_end = -1; m_delay = 0; m_wlen = 1; m_ev = 0;
    m_mask = '0; m_prev_src = '0; m_mode = 2'd0; m_seq = 1'b0; m_prev_match = 1'b0;
    m_trig = 1'b0; m_busy = 1'b0; m_armed = 1'b0; m_hb = '0;
  endtask

  task automatic model_step();
    logic prev_trig, cur;
    logic [15:0] ev;
    t++;
    if (!resetn) begin
      model_reset();
      exp_q.push_back('0);
      return;
    end
    if (!m_busy && !m_trig) m_hb = m_hb + 1'b1;
    prev_trig = m_trig;
    cur = match_of(I_src, m_prev_src, m_mask, m_mode, m_seq);
    if (I_mode == 2'd3) begin
      m_phase = M_IDLE;
      m_trig  = I_src[I_pass_idx];
      m_armed = 1'b0;
      m_busy  = 1'b0;
    end else begin
      case (m_phase)
        M_IDLE: if (I_arm) begin
          m_mask = I_mask; m_mode = I_mode; m_delay = int'(I_delay);
          m_wlen = (I_width == 0) ? 1 : int'(I_width);
          m_seq = 1'b0;
          cur = match_of(I_src, m_prev_src, I_mask, I_mode, 1'b0);
          m_phase = M_ARMED;
        end
        M_ARMED: begin
          if (cur && !m_prev_match) begin
            m_fire_t = t; m_start = t + 1 + m_delay; m_end = m_start + m_wlen - 1; m_phase = M_RUN;
          end else if (m_mode == 2'd2 && I_src[0] && !m_prev_src[0]) m_seq = 1'b1;
        end
        default: if (t > m_end) m_phase = M_IDLE;
      endcase
      m_trig  = (m_phase == M_RUN) && (t >= m_start) && (t <= m_end);
      m_armed = (m_phase == M_ARMED) || (m_phase == M_RUN && t == m_fire_t);
      m_busy  = (m_phase != M_IDLE);
    end
    m_prev_match = cur;
    m_prev_src   = I_src;
    if (m_trig && !prev_trig && m_ev < 65535) m_ev++;
`ifdef TRIG_EVENT_COUNT_EN
    ev = 16'(m_ev);
`else
    ev = 16'h0000;
`endif
    exp_q.push_back({m_trig, m_busy, m_armed, m_hb[LW-1], ev});
  endtask

  initial begin
    t = 0;
    model_reset();
    forever begin
      @(posedge ext_clock);
      model_step();
    end
  end

  // Scoreboard monitor: pop one expected output word per cycle, sampled mid-cycle
  initial begin : monitor
    logic [EW-1:0] e, a;
    forever begin
      @(negedge ext_clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {O_trig, O_busy, O_armed, O_led_heartbeat, O_event_count};
        check("cycle_out", a, e);
      end
    end
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge ext_clock);
      #1;
    end
  endtask

  task automatic do_arm(input logic [N-1:0] mask, input logic [1:0] mode, input int d, input int w);
    I_mask = mask; I_mode = mode; I_delay = DW'(d); I_width = WW'(w);
    I_arm = 1'b1;
    tick(1);
    I_arm = 1'b0;
  endtask

  task automatic pulse_src(input int idx, input int len);
    I_src[idx] = 1'b1; tick(len);
    I_src[idx] = 1'b0; tick(3);
  endtask

  initial begin
    resetn = 1'b0;
    tick(3);
    @(negedge ext_clock); #1 resetn = 1'b1;
    tick(1);

    // OR on src1 only, no delay, width 3
    do_arm(4'b0010, 2'd0, 0, 3);
    tick(4);
    I_src = 4'b0001; tick(2);
    I_src = 4'b0011; tick(8);
    I_src = 4'b0000; tick(4);

    // AND on src0/src1, delay 5, width 1
    do_arm(4'b0011, 2'd1, 5, 1);
    I_src = 4'b0001; tick(4);
    I_src = 4'b0011; tick(12);
    I_src = 4'b0000; tick(3);

    // SEQ: early src1 ignored, src0 then src1 fires once, later src1 ignored
    do_arm(4'b0011, 2'd2, 0, 2);
    pulse_src(1, 1);
    pulse_src(0, 2);
    pulse_src(1, 1);
    pulse_src(1, 1);
    tick(4);

    // OR with src0 already high at arm, width 0
    I_src = 4'b0001; tick(2);
    do_arm(4'b0001, 2'd0, 0, 0);
    tick(5);
    I_src = 4'b0000; tick(2);
    I_src = 4'b0001; tick(6);
    I_src = 4'b0000; tick(2);

    // PASS on src2 with an ignored arm, then leave PASS while src2 is high
    I_mode = 2'd3; I_pass_idx = 2'd2;
    for (int i = 0; i < 16; i++) begin
      I_src = N'($urandom_range(0, 15));
      I_arm = (i == 5);
      tick(1);
    end
    I_arm = 1'b0;
    I_src = 4'b0100; tick(2);
    I_mode = 2'd0; tick(4);
    I_src = 4'b0000; tick(2);

    // Reset during a 100-cycle pulse, then idle so the heartbeat runs
    do_arm(4'b1111, 2'd0, 0, 100);
    tick(2);
    I_src = 4'b0100; tick(20);
    @(negedge ext_clock); #1;
    check("pulse_before_reset", EW'(O_trig), EW'(1));
    resetn = 1'b0;
    #1;
    check("reset_async", EW'({O_trig, O_busy, O_armed}), EW'(0));
    I_src = 4'b0000;
    tick(2);
    @(negedge ext_clock); #1 resetn = 1'b1;
    tick(40);

    // Randomized transactions, with occasional PASS interruptions
    for (int tr = 0; tr < 40; tr++) begin
      if ($urandom_range(0, 7) == 0) begin
        I_mode = 2'd3; I_pass_idx = 2'($urandom_range(0, 3));
        for (int i = 0; i < 12; i++) begin
          I_src = N'($urandom_range(0, 15));
          I_arm = ($urandom_range(0, 3) == 0);
          tick(1);
        end
        I_arm = 1'b0;
        I_mode = 2'd0;
        tick(2);
      end else begin
        do_arm(N'($urandom_range(0, 15)), 2'($urandom_range(0, 2)),
               $urandom_range(0, 6), $urandom_range(0, 5));
        for (int i = 0; i < 30; i++) begin
          if ($urandom_range(0, 2) == 0) I_src = N'($urandom_range(0, 15));
          I_arm = ($urandom_range(0, 15) == 0);
          tick(1);
        end
        I_arm = 1'b0;
      end
    end
    I_src = 4'b0000;
    tick(20);

    @(posedge ext_clock); #6;
    check("queue_drained", EW'(exp_q.size()), EW'(0));
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
